// File: rtl/omok_pkg.sv
// Shared types and constants for the omok game controller.
package omok_pkg;

  localparam int unsigned BoardN   = 10;
  localparam int unsigned NumCells = BoardN * BoardN;
  localparam int unsigned PosW     = 7;
  localparam int unsigned WinLen   = 5;

  localparam logic ColorBlack = 1'b0;
  localparam logic ColorWhite = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StCheck,
    StOver,
    StUndo
  } state_e;

  // Scan directions in order: horizontal, vertical, diagonal, anti-diagonal.
  function automatic logic signed [7:0] dir_drow(input logic [1:0] dir);
    unique case (dir)
      2'd0:    return 8'sd0;
      default: return 8'sd1;
    endcase
  endfunction

  function automatic logic signed [7:0] dir_dcol(input logic [1:0] dir);
    unique case (dir)
      2'd0:    return 8'sd1;
      2'd1:    return 8'sd0;
      2'd2:    return 8'sd1;
      default: return -8'sd1;
    endcase
  endfunction

endpackage

// File: rtl/omok_hist_stack.sv
// Circular LIFO of placed cell positions; the oldest entry is overwritten once full.
module omok_hist_stack
  import omok_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [PosW-1:0]                data_i,
  output logic [PosW-1:0]                top_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PosW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wp_q, wp_d, wp_inc, wp_dec;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    wp_inc = (wp_q == PtrW'(Depth - 1)) ? '0 : wp_q + PtrW'(1);
    wp_dec = (wp_q == '0) ? PtrW'(Depth - 1) : wp_q - PtrW'(1);
  end

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wp_d  = '0;
      cnt_d = '0;
    end else if (push_i) begin
      wp_d = wp_inc;
      if (cnt_q != CntW'(Depth)) cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      wp_d  = wp_dec;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wp_q] <= data_i;
  end

  assign top_o   = mem_q[wp_dec];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/omok_game_ctrl.sv
// Omok (five-in-a-row) move controller with sequential win scan.
// Define OMOK_UNDO_EN to build the move history and undo support.
module omok_game_ctrl
  import omok_pkg::*;
#(
  parameter int unsigned N          = BoardN,
  parameter int unsigned HIST_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_req_i,
  input  logic [PosW-1:0]  move_pos_i,
  input  logic             undo_req_i,
  input  logic             new_game_i,
  output logic [N*N-1:0]   board_state_o,
  output logic [N*N-1:0]   turn_map_o,
  output logic             cur_color_o,
  output logic             busy_o,
  output logic             ack_o,
  output logic             nack_o,
  output logic             game_over_o,
  output logic             winner_o
);

  localparam logic signed [7:0] NSgn = 8'(N);

  state_e          state_q, state_d;
  logic [N*N-1:0]  board_q, board_d, turn_q, turn_d;
  logic            color_q, color_d, over_q, over_d, winner_q, winner_d;
  logic            ack_q, ack_d, nack_q, nack_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [3:0]      row_q, row_d, col_q, col_d;
  logic [1:0]      dir_q, dir_d;
  logic [3:0]      k_q, k_d;
  logic [2:0]      run_q, run_d;

  logic            hist_push, hist_pop, hist_clr;
  logic [PosW-1:0] hist_top;
  logic            hist_empty;

  logic signed [7:0] offs, scan_row, scan_col;
  logic [PosW-1:0]   scan_idx;
  logic              in_bounds, match, win, move_ok;
  logic [2:0]        run_base, run_nx;

  // Current scan cell: placed position offset by (k-4) steps along dir.
  always_comb begin
    offs      = $signed({4'b0, k_q}) - 8'sd4;
    scan_row  = $signed({4'b0, row_q}) + offs * dir_drow(dir_q);
    scan_col  = $signed({4'b0, col_q}) + offs * dir_dcol(dir_q);
    in_bounds = (scan_row >= 8'sd0) && (scan_row < NSgn) &&
                (scan_col >= 8'sd0) && (scan_col < NSgn);
    scan_idx  = PosW'($unsigned(scan_row) * 8'(N) + $unsigned(scan_col));
    match     = in_bounds && board_q[scan_idx] && (turn_q[scan_idx] == color_q);
    run_base  = (k_q == 4'd0) ? 3'd0 : run_q;
    run_nx    = match ? run_base + 3'd1 : 3'd0;
    win       = (run_nx == 3'(WinLen));
    move_ok   = (move_pos_i < PosW'(N * N)) && !board_q[move_pos_i];
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    color_d   = color_q;
    over_d    = over_q;
    winner_d  = winner_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    pos_d     = pos_q;
    row_d     = row_q;
    col_d     = col_q;
    dir_d     = dir_q;
    k_d       = k_q;
    run_d     = run_q;
    hist_push = 1'b0;
    hist_pop  = 1'b0;
    hist_clr  = 1'b0;

    if (new_game_i) begin
      state_d  = StIdle;
      board_d  = '0;
      turn_d   = '0;
      color_d  = ColorBlack;
      over_d   = 1'b0;
      winner_d = 1'b0;
      ack_d    = 1'b1;
      hist_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StOver: begin
          if (undo_req_i) begin
`ifdef OMOK_UNDO_EN
            if (hist_empty) nack_d = 1'b1;
            else            state_d = StUndo;
`else
            nack_d = 1'b1;
`endif
          end else if (move_req_i) begin
            if ((state_q == StOver) || !move_ok) begin
              nack_d = 1'b1;
            end else begin
              state_d = StPlace;
              pos_d   = move_pos_i;
              row_d   = 4'(move_pos_i / PosW'(N));
              col_d   = 4'(move_pos_i % PosW'(N));
            end
          end
        end
        StPlace: begin
          board_d[pos_q] = 1'b1;
          turn_d[pos_q]  = color_q;
          hist_push      = 1'b1;
          dir_d          = 2'd0;
          k_d            = 4'd0;
          run_d          = 3'd0;
          state_d        = StCheck;
        end
        StCheck: begin
          run_d = run_nx;
          if (win) begin
            state_d  = StOver;
            over_d   = 1'b1;
            winner_d = color_q;
            ack_d    = 1'b1;
          end else if (k_q == 4'd8) begin
            k_d = 4'd0;
            if (dir_q == 2'd3) begin
              color_d = ~color_q;
              state_d = StIdle;
              ack_d   = 1'b1;
            end else begin
              dir_d = dir_q + 2'd1;
            end
          end else begin
            k_d = k_q + 4'd1;
          end
        end
`ifdef OMOK_UNDO_EN
        StUndo: begin
          board_d[hist_top] = 1'b0;
          turn_d[hist_top]  = 1'b0;
          hist_pop          = 1'b1;
          color_d           = ~color_q;
          over_d            = 1'b0;
          ack_d             = 1'b1;
          state_d           = StIdle;
        end
`endif
        default: state_d = StIdle;
      endcase

      if ((state_q != StIdle) && (state_q != StOver) && (move_req_i || undo_req_i)) begin
        nack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      board_q  <= '0;
      turn_q   <= '0;
      color_q  <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      pos_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dir_q    <= '0;
      k_q      <= '0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      color_q  <= color_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      pos_q    <= pos_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dir_q    <= dir_d;
      k_q      <= k_d;
      run_q    <= run_d;
    end
  end

`ifdef OMOK_UNDO_EN
  logic [$clog2(HIST_DEPTH+1)-1:0] hist_cnt;

  omok_hist_stack #(
    .Depth (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (hist_clr),
    .push_i  (hist_push),
    .pop_i   (hist_pop),
    .data_i  (pos_q),
    .top_o   (hist_top),
    .empty_o (hist_empty),
    .count_o (hist_cnt)
  );
`else
  assign hist_top   = '0;
  assign hist_empty = 1'b1;
`endif

  assign board_state_o = board_q;
  assign turn_map_o    = turn_q;
  assign cur_color_o   = color_q;
  assign busy_o        = (state_q != StIdle);
  assign ack_o         = ack_q;
  assign nack_o        = nack_q;
  assign game_over_o   = over_q;
  assign winner_o      = winner_q;

endmodule

// File: tb/tb_omok_game_ctrl.sv
// Directed bench for omok_game_ctrl; undo coverage depends on OMOK_UNDO_EN.
module tb_omok_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_req, undo_req, new_game;
  logic [6:0]  move_pos;
  logic [99:0] board_state, turn_map;
  logic        cur_color, busy, ack, nack, game_over, winner;

  int errors = 0;
  int checks = 0;

  omok_game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .move_req_i    (move_req),
    .move_pos_i    (move_pos),
    .undo_req_i    (undo_req),
    .new_game_i    (new_game),
    .board_state_o (board_state),
    .turn_map_o    (turn_map),
    .cur_color_o   (cur_color),
    .busy_o        (busy),
    .ack_o         (ack),
    .nack_o        (nack),
    .game_over_o   (game_over),
    .winner_o      (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse move_req, return edges from request sample to ack (100 = timed out).
  task automatic do_move(input int pos, output int lat);
    @(negedge clk);
    move_pos = 7'(pos);
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    lat = 1;
    while (!ack && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (!ack && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse_move_nack(input string tag, input int pos);
    @(negedge clk);
    move_pos = 7'(pos);
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    check(tag, nack, 1'b1);
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("new_game_ack", ack, 1'b1);
  endtask

  logic [99:0] exp_board, exp_turn;
  int lat, pulses;

  initial begin
    rst = 1'b1; move_req = 1'b0; undo_req = 1'b0; new_game = 1'b0; move_pos = '0;
    #12;
    check("rst_board", board_state, 100'd0);
    check("rst_outs", {turn_map != 0, cur_color, busy, ack, nack, game_over, winner}, 7'd0);
    @(negedge clk);
    rst = 1'b0;

    // First move: black at 45, full no-win latency.
    do_move(45, lat);
    check("move45_latency", lat, 38);
    exp_board = '0; exp_board[45] = 1'b1;
    check("move45_board", board_state, exp_board);
    check("move45_turn", turn_map, 100'd0);
    check("move45_color", cur_color, 1'b1);
    @(negedge clk);
    check("ack_one_cycle", ack, 1'b0);

    pulse_move_nack("nack_occupied", 45);
    pulse_move_nack("nack_range", 100);
    check("nack_board_same", board_state, exp_board);

    // Move request arriving during CHECK is rejected.
    @(negedge clk);
    move_pos = 7'd46;
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_check", busy, 1'b1);
    move_pos = 7'd47;
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    check("nack_during_check", nack, 1'b1);
    wait_ack(lat);
    exp_board[46] = 1'b1;
    exp_turn = '0; exp_turn[46] = 1'b1;
    check("busy_board", board_state, exp_board);
    check("busy_turn", turn_map, exp_turn);
    check("busy_color", cur_color, 1'b0);

    do_new_game();
    check("ng_board", board_state, 100'd0);

    // Black 7..11 wraps from row 0 to row 1: not a win.
    do_move(7, lat);  do_move(60, lat);
    do_move(8, lat);  do_move(61, lat);
    do_move(9, lat);  do_move(62, lat);
    do_move(10, lat); do_move(63, lat);
    do_move(11, lat);
    check("wrap_latency", lat, 38);
    check("wrap_no_win", game_over, 1'b0);

    // Black horizontal five ending at 44: found after 5 scan cycles.
    do_new_game();
    do_move(40, lat); do_move(50, lat);
    do_move(41, lat); do_move(51, lat);
    do_move(42, lat); do_move(52, lat);
    do_move(43, lat); do_move(53, lat);
    do_move(44, lat);
    check("win_latency", lat, 7);
    check("win_over", game_over, 1'b1);
    check("win_winner", winner, 1'b0);
    check("win_busy", busy, 1'b1);
    exp_board = '0;
    for (int i = 40; i <= 44; i++) exp_board[i] = 1'b1;
    for (int i = 50; i <= 53; i++) exp_board[i] = 1'b1;
    pulse_move_nack("nack_in_over", 60);
    check("over_board_same", board_state, exp_board);

    // new_game beats undo_req in the same cycle.
    @(negedge clk);
    new_game = 1'b1;
    undo_req = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    undo_req = 1'b0;
    check("ng_undo_ack", {ack, nack}, 2'b10);
    check("ng_undo_board", board_state, 100'd0);
    check("ng_undo_state", {game_over, cur_color, busy}, 3'b000);
    @(negedge clk);
    check("ng_undo_single", {ack, nack}, 2'b00);

    // White vertical five in column 3: found in second direction.
    do_move(0, lat);  do_move(13, lat);
    do_move(1, lat);  do_move(23, lat);
    do_move(2, lat);  do_move(33, lat);
    do_move(3, lat);  do_move(43, lat);
    do_move(5, lat);  do_move(53, lat);
    check("wwin_latency", lat, 16);
    check("wwin_flags", {game_over, winner}, 2'b11);

    do_new_game();
`ifdef OMOK_UNDO_EN
    for (int i = 0; i < 17; i++) do_move(i, lat);
    check("hist_color", cur_color, 1'b1);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      undo_req = 1'b1;
      @(negedge clk);
      undo_req = 1'b0;
      wait_ack(lat);
      if (ack) pulses++;
      if (i == 0) begin
        exp_board = '0;
        for (int j = 0; j < 16; j++) exp_board[j] = 1'b1;
        check("undo_first_board", board_state, exp_board);
      end
    end
    check("undo_ack_count", pulses, 16);
    @(negedge clk);
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    check("undo_empty_nack", nack, 1'b1);
    exp_board = '0; exp_board[0] = 1'b1;
    check("undo_board", board_state, exp_board);
    check("undo_turn", turn_map, 100'd0);
    check("undo_color", cur_color, 1'b1);
`else
    do_move(0, lat);
    @(negedge clk);
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    check("undo_disabled_nack", nack, 1'b1);
    exp_board = '0; exp_board[0] = 1'b1;
    check("undo_disabled_board", board_state, exp_board);
`endif

    // Reset in the middle of a scan drops everything without a pulse.
    do_new_game();
    @(negedge clk);
    move_pos = 7'd20;
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_board", board_state, 100'd0);
    check("midrst_outs", {busy, ack, nack, cur_color, game_over}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack || nack) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    do_move(20, lat);
    check("after_rst_latency", lat, 38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/omok_game_ctrl.md
OMOK_GAME_CTRL -- requirements
Module: omok_game_ctrl

Interface
REQ-001 Parameter N, default 10, board dimension; cells indexed pos = row*N + col, 0..N*N-1.
REQ-002 Parameter HIST_DEPTH, default 16, move-history entries for undo.
REQ-003 clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-004 move_req  input  1  single-cycle move request; move_pos  input  7  target cell.
REQ-005 undo_req  input  1  single-cycle undo request; new_game  input  1  single-cycle board clear.
REQ-006 board_state  output  N*N  cell occupied; turn_map  output  N*N  stone colour (0 black, 1 white), valid where occupied.
REQ-007 cur_color  output  1  colour to move next; busy  output  1  high outside IDLE.
REQ-008 ack  output  1  one-cycle pulse, request completed; nack  output  1  one-cycle pulse, request rejected.
REQ-009 game_over  output  1  five-in-row found; winner  output  1  colour of winner, valid while game_over.

Function
REQ-010 States: IDLE, PLACE, CHECK, OVER, UNDO; requests sampled only in IDLE and OVER.
REQ-011 Same-cycle priority: new_game > undo_req > move_req; lower-priority requests dropped silently.
REQ-012 new_game in any state: next cycle board_state, turn_map, history cleared, cur_color=0, game_over=0, state IDLE, ack pulse.
REQ-013 move_req in IDLE rejected (nack next cycle, no state change) if move_pos >= N*N or cell occupied.
REQ-014 Accepted move: PLACE (1 cycle) sets board_state[pos]=1, turn_map[pos]=cur_color, pushes pos to history, then CHECK.
REQ-015 CHECK scans directions in order (0,+1),(+1,0),(+1,+1),(+1,-1), offsets k=-4..+4, one cell per cycle, 9 cycles per direction.
REQ-016 Off-board test uses row/col bounds, never linear wrap; off-board or mismatched cell resets run count to 0, match increments.
REQ-017 Run count reaching 5 ends CHECK immediately: game_over=1, winner=placed colour, state OVER, ack pulse.
REQ-018 No win after 36 scan cycles: cur_color toggles, state IDLE, ack pulse; total move latency 38 cycles request-to-ack.
REQ-019 move_req, undo_req received in PLACE/CHECK/UNDO: nack next cycle, request discarded.
REQ-020 move_req in OVER: nack; undo_req in OVER: permitted, clears game_over.
REQ-021 Undo: history empty -> nack; else UNDO (1 cycle) pops pos, clears board_state[pos] and turn_map[pos], toggles cur_color, game_over=0, state IDLE, ack.
REQ-022 History full on push: oldest entry overwritten (circular), count saturates at HIST_DEPTH.
REQ-023 Full board without win: no special state; further moves nack as occupied.

Reset
REQ-024 rst asserted any cycle: state IDLE, all outputs 0, history count 0, scan counters 0, effective immediately.
REQ-025 Reset mid-CHECK abandons scan; no ack/nack pulse generated.

Configuration
REQ-026 Macro OMOK_UNDO_EN defined: history and UNDO state present as specified.
REQ-027 OMOK_UNDO_EN undefined: no history storage, undo_req always answered with nack, UNDO state absent.

Structure
REQ-028 Package omok_pkg: N default, cell count, state enum, colour encoding, direction (drow,dcol) table, win length 5.
REQ-029 Sub-module omok_hist_stack: circular LIFO of HIST_DEPTH x 7 bits, push/pop/empty/count.
REQ-030 Scan datapath (row/col stepping, run counter) stays in omok_game_ctrl.

Verification
REQ-031 Reset, move_req pos 45 -> ack at cycle 38, board_state[45]=1, turn_map[45]=0, cur_color=1.
REQ-032 Black at 40..44 (white at 50..53 interleaved) -> after pos 44 game_over=1, winner=0, ack before 36 scan cycles.
REQ-033 Black at 7,8,9,10,11 (row wrap) -> no win, game_over stays 0.
REQ-034 move_req to occupied cell and move_req during CHECK -> nack each, board unchanged.
REQ-035 17 moves then 17 undos (HIST_DEPTH 16) -> 16 acks restoring moves 17..2, 17th nack, move 1 remains.
REQ-036 new_game and undo_req same cycle in OVER -> board cleared, single ack, game_over=0, cur_color=0.
